// File: rtl/x86_operand_encoder_if.sv
// Request/response bundle for the x86 operand encoder.
//   in_*  : one decoded instruction, valid/ready handshake (master drives, slave accepts)
//   out_* : encoded byte stream, valid/ready handshake (slave drives, master sinks)
//   err   : one-cycle pulse when a request is rejected
interface x86_operand_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_opcode;
  logic [1:0]  in_opsize;
  logic        in_has_modrm;
  logic        in_rm_is_reg;
  logic        in_rip_rel;
  logic [3:0]  in_reg;
  logic [3:0]  in_base;
  logic        in_base_valid;
  logic [3:0]  in_index;
  logic        in_index_valid;
  logic [1:0]  in_scale;
  logic [31:0] in_disp;
  logic [63:0] in_imm;
  logic [3:0]  in_imm_size;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic [4:0]  out_count;
  logic        err;

  modport master (
    output in_valid, in_opcode, in_opsize, in_has_modrm, in_rm_is_reg, in_rip_rel,
           in_reg, in_base, in_base_valid, in_index, in_index_valid, in_scale,
           in_disp, in_imm, in_imm_size, out_ready,
    input  in_ready, out_valid, out_byte, out_last, out_count, err
  );

  modport slave (
    input  in_valid, in_opcode, in_opsize, in_has_modrm, in_rm_is_reg, in_rip_rel,
           in_reg, in_base, in_base_valid, in_index, in_index_valid, in_scale,
           in_disp, in_imm, in_imm_size, out_ready,
    output in_ready, out_valid, out_byte, out_last, out_count, err
  );
endinterface

// File: rtl/x86_operand_encoder.sv
// Serialises one decoded x86-64 instruction into its byte encoding, one byte
// per cycle: 66 prefix, REX, opcode, ModRM, SIB, displacement, immediate.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of x86_operand_encoder_if (request in, bytes out, err)
module x86_operand_encoder #(
  parameter int unsigned IMM_MAX_BYTES = 8,
  parameter bit          DISP8_OPT     = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  x86_operand_encoder_if.slave bus
);
  localparam int unsigned CntW = 5;

  typedef enum logic [3:0] {IDLE, PFX, REX, OPC, MODRM, SIB, DISP, IMM, ERR} state_e;

  state_e          state_q, state_d, nxt;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      byte_q, byte_d;
  logic [CntW-1:0] count_q, count_d;
  logic            last_q, last_d, valid_q, valid_d, err_q, in_ready_q, latch_en;

  // Decoded view of the incoming request
  logic            imm_size_ok, dec_err, dec_pfx, dec_rex, dec_sib, need_sib, disp_is8;
  logic [7:0]      dec_rex_byte, dec_modrm, dec_sib_byte;
  logic [1:0]      mod_f;
  logic [2:0]      rm_f, dec_dlen;
  logic [CntW-1:0] dec_len;

  // Fields captured at acceptance
  logic            lat_pfx, lat_rex, lat_has_modrm, lat_sib;
  logic [7:0]      lat_rex_byte, lat_opc, lat_modrm, lat_sib_byte;
  logic [2:0]      lat_dlen;
  logic [3:0]      lat_ilen;
  logic [31:0]     lat_disp;
  logic [63:0]     lat_imm;
  logic [CntW-1:0] lat_len;

  // First needed state at or after s (ERR acts as "past the end")
  function automatic state_e first_from(state_e s, logic pfx, logic rex, logic modrm,
                                        logic sib, logic [2:0] dlen, logic [3:0] ilen);
    state_e r;
    r = IDLE;
    if (s <= IMM && ilen != 4'd0) r = IMM;
    if (s <= DISP && dlen != 3'd0) r = DISP;
    if (s <= SIB && sib) r = SIB;
    if (s <= MODRM && modrm) r = MODRM;
    if (s <= OPC) r = OPC;
    if (s <= REX && rex) r = REX;
    if (s <= PFX && pfx) r = PFX;
    return r;
  endfunction

  function automatic state_e succ(state_e s);
    case (s)
      IDLE:    return PFX;
      PFX:     return REX;
      REX:     return OPC;
      OPC:     return MODRM;
      MODRM:   return SIB;
      SIB:     return DISP;
      DISP:    return IMM;
      default: return ERR;
    endcase
  endfunction

  function automatic logic [7:0] byte_for(state_e s, logic [2:0] idx, logic [7:0] rex,
                                          logic [7:0] opc, logic [7:0] modrm, logic [7:0] sib,
                                          logic [31:0] disp, logic [63:0] imm);
    case (s)
      PFX:     return 8'h66;
      REX:     return rex;
      OPC:     return opc;
      MODRM:   return modrm;
      SIB:     return sib;
      DISP:    return 8'(disp >> {idx[1:0], 3'b000});
      IMM:     return 8'(imm >> {idx, 3'b000});
      default: return 8'h00;
    endcase
  endfunction

  // Request decode: validity, REX, ModRM/SIB and displacement width
  always_comb begin
    imm_size_ok  = (bus.in_imm_size inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd8}) &&
                   (32'(bus.in_imm_size) <= IMM_MAX_BYTES);
    dec_err      = (bus.in_index_valid && bus.in_index == 4'b0100) || (bus.in_opsize == 2'd3) ||
                   !imm_size_ok || (bus.in_rip_rel && bus.in_index_valid);
    dec_pfx      = (bus.in_opsize == 2'd1);
    dec_rex_byte = {4'b0100, bus.in_opsize == 2'd2, bus.in_has_modrm & bus.in_reg[3],
                    bus.in_index_valid & bus.in_index[3], bus.in_base[3]};
    dec_rex      = |dec_rex_byte[3:0];
    disp_is8     = (bus.in_disp[31:7] == '0) || (bus.in_disp[31:7] == '1);
    need_sib     = 1'b0;
    mod_f        = 2'b00;
    rm_f         = 3'b000;
    dec_dlen     = 3'd0;
    if (bus.in_rm_is_reg) begin
      mod_f = 2'b11;
      rm_f  = bus.in_base[2:0];
    end else if (bus.in_rip_rel) begin
      rm_f     = 3'b101;
      dec_dlen = 3'd4;
    end else begin
      need_sib = bus.in_index_valid || !bus.in_base_valid || bus.in_base[2:0] == 3'b100;
      rm_f     = need_sib ? 3'b100 : bus.in_base[2:0];
      if (!bus.in_base_valid) begin
        dec_dlen = 3'd4;
      end else if (!DISP8_OPT) begin
        mod_f    = 2'b10;
        dec_dlen = 3'd4;
      end else if (bus.in_disp == 32'd0 && bus.in_base[2:0] != 3'b101) begin
        mod_f = 2'b00;
      end else if (disp_is8) begin
        mod_f    = 2'b01;
        dec_dlen = 3'd1;
      end else begin
        mod_f    = 2'b10;
        dec_dlen = 3'd4;
      end
    end
    dec_modrm    = {mod_f, bus.in_reg[2:0], rm_f};
    dec_sib_byte = {bus.in_scale, bus.in_index_valid ? bus.in_index[2:0] : 3'b100,
                    bus.in_base_valid ? bus.in_base[2:0] : 3'b101};
    dec_sib      = bus.in_has_modrm && need_sib;
    if (!bus.in_has_modrm) dec_dlen = 3'd0;
    dec_len = CntW'(dec_pfx) + CntW'(dec_rex) + CntW'(1) + CntW'(bus.in_has_modrm) +
              CntW'(dec_sib) + CntW'(dec_dlen) + CntW'(bus.in_imm_size);
  end

  // Next-state and next output byte
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    count_d  = count_q;
    last_d   = last_q;
    latch_en = 1'b0;
    nxt      = IDLE;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          latch_en = 1'b1;
          if (dec_err) begin
            state_d = ERR;
          end else begin
            nxt     = first_from(PFX, dec_pfx, dec_rex, bus.in_has_modrm, dec_sib, dec_dlen,
                                 bus.in_imm_size);
            state_d = nxt;
            idx_d   = 4'd0;
            byte_d  = byte_for(nxt, 3'd0, dec_rex_byte, bus.in_opcode, dec_modrm, dec_sib_byte,
                               bus.in_disp, bus.in_imm);
            count_d = CntW'(1);
            last_d  = (dec_len == CntW'(1));
          end
        end
      end
      ERR: state_d = IDLE;
      default: begin
        if (bus.out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            byte_d  = 8'h00;
            count_d = '0;
            last_d  = 1'b0;
          end else begin
            // Multi-byte fields stay in their state until all bytes are out
            if ((state_q == DISP && (idx_q + 4'd1) < {1'b0, lat_dlen}) ||
                (state_q == IMM && (idx_q + 4'd1) < lat_ilen)) begin
              nxt   = state_q;
              idx_d = idx_q + 4'd1;
            end else begin
              nxt   = first_from(succ(state_q), lat_pfx, lat_rex, lat_has_modrm, lat_sib,
                                 lat_dlen, lat_ilen);
              idx_d = 4'd0;
            end
            state_d = nxt;
            byte_d  = byte_for(nxt, idx_d[2:0], lat_rex_byte, lat_opc, lat_modrm, lat_sib_byte,
                               lat_disp, lat_imm);
            count_d = count_q + CntW'(1);
            last_d  = (count_d == lat_len);
          end
        end
      end
    endcase
    valid_d = !(state_d inside {IDLE, ERR});
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      byte_q     <= '0;
      count_q    <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      count_q    <= count_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
      err_q      <= (state_d == ERR);
      in_ready_q <= (state_d == IDLE);
    end
  end

  // Request capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_pfx       <= 1'b0;
      lat_rex       <= 1'b0;
      lat_has_modrm <= 1'b0;
      lat_sib       <= 1'b0;
      lat_rex_byte  <= '0;
      lat_opc       <= '0;
      lat_modrm     <= '0;
      lat_sib_byte  <= '0;
      lat_dlen      <= '0;
      lat_ilen      <= '0;
      lat_disp      <= '0;
      lat_imm       <= '0;
      lat_len       <= '0;
    end else if (latch_en) begin
      lat_pfx       <= dec_pfx;
      lat_rex       <= dec_rex;
      lat_has_modrm <= bus.in_has_modrm;
      lat_sib       <= dec_sib;
      lat_rex_byte  <= dec_rex_byte;
      lat_opc       <= bus.in_opcode;
      lat_modrm     <= dec_modrm;
      lat_sib_byte  <= dec_sib_byte;
      lat_dlen      <= dec_dlen;
      lat_ilen      <= bus.in_imm_size;
      lat_disp      <= bus.in_disp;
      lat_imm       <= bus.in_imm;
      lat_len       <= dec_len;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_byte  = byte_q;
  assign bus.out_last  = last_q;
  assign bus.out_count = count_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_x86_operand_encoder.sv
// Directed bench for x86_operand_encoder: two instances (short-displacement
// forms enabled / disabled) fed the same requests, checked against
// hand-encoded byte sequences.
module tb_x86_operand_encoder;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  x86_operand_encoder_if bus0();
  x86_operand_encoder_if bus1();

  assign bus1.in_valid       = bus0.in_valid;
  assign bus1.in_opcode      = bus0.in_opcode;
  assign bus1.in_opsize      = bus0.in_opsize;
  assign bus1.in_has_modrm   = bus0.in_has_modrm;
  assign bus1.in_rm_is_reg   = bus0.in_rm_is_reg;
  assign bus1.in_rip_rel     = bus0.in_rip_rel;
  assign bus1.in_reg         = bus0.in_reg;
  assign bus1.in_base        = bus0.in_base;
  assign bus1.in_base_valid  = bus0.in_base_valid;
  assign bus1.in_index       = bus0.in_index;
  assign bus1.in_index_valid = bus0.in_index_valid;
  assign bus1.in_scale       = bus0.in_scale;
  assign bus1.in_disp        = bus0.in_disp;
  assign bus1.in_imm         = bus0.in_imm;
  assign bus1.in_imm_size    = bus0.in_imm_size;
  assign bus1.out_ready      = bus0.out_ready;

  x86_operand_encoder #(.IMM_MAX_BYTES(8), .DISP8_OPT(1'b1)) u_dut (
    .clk(clk), .reset(reset), .bus(bus0));
  x86_operand_encoder #(.IMM_MAX_BYTES(8), .DISP8_OPT(1'b0)) u_dut_d32 (
    .clk(clk), .reset(reset), .bus(bus1));

  typedef struct packed {
    logic [7:0]        opc;
    logic [1:0]        opsize;
    logic              has_modrm;
    logic              rm_is_reg;
    logic              rip_rel;
    logic [3:0]        regf;
    logic [3:0]        base;
    logic              base_valid;
    logic [3:0]        index;
    logic              index_valid;
    logic [1:0]        scale;
    logic [31:0]       disp;
    logic [63:0]       imm;
    logic [3:0]        imm_size;
    logic              exp_err;
    logic [4:0]        n0;
    logic [0:16][7:0]  e0;
    logic [4:0]        n1;
    logic [0:16][7:0]  e1;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  // Expected bytes are given right-aligned; byte 0 ends up in element 0.
  // n1 == 0 means the disp32-only instance expects the same bytes.
  function automatic vec_t mkv(logic [7:0] opc, logic [1:0] opsize, logic has_modrm,
                               logic rm_is_reg, logic rip_rel, logic [3:0] regf,
                               logic [3:0] base, logic bv, logic [3:0] index, logic iv,
                               logic [1:0] scale, logic [31:0] disp, logic [63:0] imm,
                               logic [3:0] isz, logic exp_err, int n0, logic [135:0] e0,
                               int n1, logic [135:0] e1);
    vec_t v;
    v.opc = opc; v.opsize = opsize; v.has_modrm = has_modrm; v.rm_is_reg = rm_is_reg;
    v.rip_rel = rip_rel; v.regf = regf; v.base = base; v.base_valid = bv;
    v.index = index; v.index_valid = iv; v.scale = scale; v.disp = disp; v.imm = imm;
    v.imm_size = isz; v.exp_err = exp_err;
    v.n0 = 5'(n0);
    v.e0 = e0 << (8 * (17 - n0));
    if (n1 == 0) begin
      v.n1 = v.n0;
      v.e1 = v.e0;
    end else begin
      v.n1 = 5'(n1);
      v.e1 = e1 << (8 * (17 - n1));
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus0.in_opcode      = v.opc;
    bus0.in_opsize      = v.opsize;
    bus0.in_has_modrm   = v.has_modrm;
    bus0.in_rm_is_reg   = v.rm_is_reg;
    bus0.in_rip_rel     = v.rip_rel;
    bus0.in_reg         = v.regf;
    bus0.in_base        = v.base;
    bus0.in_base_valid  = v.base_valid;
    bus0.in_index       = v.index;
    bus0.in_index_valid = v.index_valid;
    bus0.in_scale       = v.scale;
    bus0.in_disp        = v.disp;
    bus0.in_imm         = v.imm;
    bus0.in_imm_size    = v.imm_size;
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 50 && !(bus0.in_ready && bus1.in_ready); t++) @(negedge clk);
    chk("idle_wait", 64'(bus0.in_ready & bus1.in_ready), 64'd1);
  endtask

  task automatic accept(input vec_t v);
    drive(v);
    bus0.in_valid = 1'b1;
    @(posedge clk);
    #1 bus0.in_valid = 1'b0;
  endtask

  task automatic run_vec(input int k);
    vec_t       v;
    logic [7:0] g0[20], g1[20];
    logic [4:0] c0[20], c1[20];
    logic       l0[20], l1[20];
    int         n0, n1, er0, er1, vs0, vs1;
    bit         d0, d1;
    v = vecs[k];
    n0 = 0; n1 = 0; er0 = 0; er1 = 0; vs0 = 0; vs1 = 0; d0 = 0; d1 = 0;
    wait_idle();
    accept(v);
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (cyc == 0 && !v.exp_err) chk($sformatf("v%0d first_valid", k), 64'(bus0.out_valid), 64'd1);
      if (bus0.err) er0++;
      if (bus1.err) er1++;
      if (bus0.out_valid) vs0++;
      if (bus1.out_valid) vs1++;
      if (!d0 && bus0.out_valid && bus0.out_ready) begin
        if (n0 < 20) begin g0[n0] = bus0.out_byte; c0[n0] = bus0.out_count; l0[n0] = bus0.out_last; end
        n0++;
        if (bus0.out_last) d0 = 1;
      end
      if (!d1 && bus1.out_valid && bus1.out_ready) begin
        if (n1 < 20) begin g1[n1] = bus1.out_byte; c1[n1] = bus1.out_count; l1[n1] = bus1.out_last; end
        n1++;
        if (bus1.out_last) d1 = 1;
      end
      if (v.exp_err ? (cyc >= 3) : (d0 && d1)) break;
    end
    if (v.exp_err) begin
      chk($sformatf("v%0d err_pulse0", k), 64'(er0), 64'd1);
      chk($sformatf("v%0d err_pulse1", k), 64'(er1), 64'd1);
      chk($sformatf("v%0d err_no_valid", k), 64'(vs0 + vs1), 64'd0);
      chk($sformatf("v%0d err_ready_after", k), 64'(bus0.in_ready & bus1.in_ready), 64'd1);
    end else begin
      chk($sformatf("v%0d done0", k), 64'(d0), 64'd1);
      chk($sformatf("v%0d done1", k), 64'(d1), 64'd1);
      chk($sformatf("v%0d no_err", k), 64'(er0 + er1), 64'd0);
      chk($sformatf("v%0d len0", k), 64'(n0), 64'(v.n0));
      chk($sformatf("v%0d len1", k), 64'(n1), 64'(v.n1));
      for (int i = 0; i < n0 && i < int'(v.n0) && i < 17; i++) begin
        chk($sformatf("v%0d byte0[%0d]", k, i), 64'(g0[i]), 64'(v.e0[i]));
        chk($sformatf("v%0d count0[%0d]", k, i), 64'(c0[i]), 64'(i + 1));
        chk($sformatf("v%0d last0[%0d]", k, i), 64'(l0[i]), 64'(i == int'(v.n0) - 1));
      end
      for (int i = 0; i < n1 && i < int'(v.n1) && i < 17; i++) begin
        chk($sformatf("v%0d byte1[%0d]", k, i), 64'(g1[i]), 64'(v.e1[i]));
        chk($sformatf("v%0d count1[%0d]", k, i), 64'(c1[i]), 64'(i + 1));
        chk($sformatf("v%0d last1[%0d]", k, i), 64'(l1[i]), 64'(i == int'(v.n1) - 1));
      end
    end
  endtask

  initial begin
    int t;
    vecs[0]  = mkv(8'hB8, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 64'h1122334455667788, 8, 0,
                   10, 136'({8'h48, 8'hB8, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}), 0, '0);
    vecs[1]  = mkv(8'h01, 0, 1, 0, 0, 0, 3, 1, 1, 1, 2, 32'h10, 64'h0, 0, 0,
                   4, 136'({8'h01, 8'h44, 8'h8B, 8'h10}),
                   7, 136'({8'h01, 8'h84, 8'h8B, 8'h10, 8'h00, 8'h00, 8'h00}));
    vecs[2]  = mkv(8'h8B, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 32'h0, 64'h0, 0, 0,
                   3, 136'({8'h8B, 8'h45, 8'h00}),
                   6, 136'({8'h8B, 8'h85, 8'h00, 8'h00, 8'h00, 8'h00}));
    vecs[3]  = mkv(8'h89, 2, 1, 0, 0, 9, 12, 1, 0, 0, 0, 32'h200, 64'h0, 0, 0,
                   8, 136'({8'h4D, 8'h89, 8'h8C, 8'h24, 8'h00, 8'h02, 8'h00, 8'h00}), 0, '0);
    vecs[4]  = mkv(8'h8D, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'hFFFFFFF0, 64'h0, 0, 0,
                   7, 136'({8'h66, 8'h8D, 8'h05, 8'hF0, 8'hFF, 8'hFF, 8'hFF}), 0, '0);
    vecs[5]  = mkv(8'h8B, 0, 1, 0, 0, 2, 1, 1, 0, 0, 0, 32'h0, 64'h0, 0, 0,
                   2, 136'({8'h8B, 8'h11}),
                   6, 136'({8'h8B, 8'h91, 8'h00, 8'h00, 8'h00, 8'h00}));
    vecs[6]  = mkv(8'h81, 0, 1, 1, 0, 0, 9, 1, 0, 0, 0, 32'h0, 64'h12345678, 4, 0,
                   7, 136'({8'h41, 8'h81, 8'hC1, 8'h78, 8'h56, 8'h34, 8'h12}), 0, '0);
    vecs[7]  = mkv(8'h8D, 0, 1, 0, 0, 1, 0, 0, 3, 1, 3, 32'h1000, 64'h0, 0, 0,
                   7, 136'({8'h8D, 8'h0C, 8'hDD, 8'h00, 8'h10, 8'h00, 8'h00}), 0, '0);
    vecs[8]  = mkv(8'h8B, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'hFFFFFFF8, 64'hBEEF, 2, 0,
                   6, 136'({8'h66, 8'h8B, 8'h40, 8'hF8, 8'hEF, 8'hBE}),
                   9, 136'({8'h66, 8'h8B, 8'h80, 8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'hEF, 8'hBE}));
    vecs[9]  = mkv(8'h8B, 0, 1, 0, 0, 0, 2, 1, 0, 0, 0, 32'h80, 64'h0, 0, 0,
                   6, 136'({8'h8B, 8'h82, 8'h80, 8'h00, 8'h00, 8'h00}), 0, '0);
    vecs[10] = mkv(8'hC3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 64'h0, 0, 0,
                   1, 136'(8'hC3), 0, '0);
    vecs[11] = mkv(8'hC7, 1, 1, 0, 0, 8, 4, 1, 9, 1, 1, 32'h12345678, 64'h0102030405060708, 8, 0,
                   17, {8'h66, 8'h46, 8'hC7, 8'h84, 8'h4C, 8'h78, 8'h56, 8'h34, 8'h12,
                        8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 0, '0);
    vecs[12] = mkv(8'h8B, 0, 1, 0, 0, 0, 3, 1, 4, 1, 0, 32'h0, 64'h0, 0, 1, 0, '0, 0, '0);
    vecs[13] = mkv(8'h90, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 64'h0, 0, 1, 0, '0, 0, '0);
    vecs[14] = mkv(8'hB8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 64'h1, 3, 1, 0, '0, 0, '0);
    vecs[15] = mkv(8'h8B, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 32'h0, 64'h0, 0, 1, 0, '0, 0, '0);
    vecs[16] = mkv(8'h05, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 64'h1234, 2, 0,
                   4, 136'({8'h66, 8'h05, 8'h34, 8'h12}), 0, '0);

    reset = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    drive(vecs[10]);
    #1;
    chk("rst in_ready", 64'(bus0.in_ready), 64'd1);
    chk("rst out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst out_byte", 64'(bus0.out_byte), 64'd0);
    chk("rst out_last", 64'(bus0.out_last), 64'd0);
    chk("rst out_count", 64'(bus0.out_count), 64'd0);
    chk("rst err", 64'(bus0.err), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < NV; k++) run_vec(k);

    // Backpressure on byte 3 of the SIB/disp8 request
    wait_idle();
    accept(vecs[1]);
    for (t = 0; t < 20 && bus0.out_count != 5'd3; t++) @(negedge clk);
    bus0.out_ready = 1'b0;
    chk("bp reach", 64'(bus0.out_count), 64'd3);
    repeat (3) begin
      @(negedge clk);
      chk("bp byte", 64'(bus0.out_byte), 64'h8B);
      chk("bp count", 64'(bus0.out_count), 64'd3);
      chk("bp valid", 64'(bus0.out_valid), 64'd1);
      chk("bp last", 64'(bus0.out_last), 64'd0);
      chk("bp in_ready", 64'(bus0.in_ready), 64'd0);
    end
    bus0.out_ready = 1'b1;
    @(negedge clk);
    chk("bp next byte", 64'(bus0.out_byte), 64'h10);
    chk("bp next count", 64'(bus0.out_count), 64'd4);
    chk("bp next last", 64'(bus0.out_last), 64'd1);
    @(negedge clk);
    chk("bp idle ready", 64'(bus0.in_ready), 64'd1);
    chk("bp idle valid", 64'(bus0.out_valid), 64'd0);

    // Reset in the middle of a 10-byte instruction
    wait_idle();
    accept(vecs[0]);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst out_valid", 64'(bus0.out_valid), 64'd0);
    chk("midrst out_count", 64'(bus0.out_count), 64'd0);
    chk("midrst in_ready", 64'(bus0.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    run_vec(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
